// File: rtl/clint_mtime_timer_pkg.sv
// Shared CLINT definitions: register offsets, APB handshake states and the
// byte-strobe merge used by every writable register.
`timescale 1ns/1ps
package clint_mtime_timer_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apbstate_t;

    // Strobed bytes take the new value; unstrobed bytes keep the old one.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  be);
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_mtime_timer_tick.sv
// mtime prescaler: pulses tick once every TICK_DIV clk cycles (every cycle when TICK_DIV=1).
`timescale 1ns/1ps
module mtime_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_mtime_timer.sv
// CLINT subset for one hart: APB slave over msip/mtimecmp/mtime, free-running
// mtime and registered timer/software interrupt lines.
`timescale 1ns/1ps
module clint_mtime_timer
    import clint_mtime_timer_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [15:0]       PADDR,
    input  logic [XLEN-1:0]   PWDATA,
    input  logic [XLEN/8-1:0] PSTRB,
    output logic [XLEN-1:0]   PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [63:0]       MTIME_CLINT,
    output logic              MTimerInt,
    output logic              MSwInt
);
    localparam bit X32 = (XLEN == 32);

    apbstate_t   state_q, state_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d, mti_q, msi_q;
    logic        tick, access, commit;
    logic        lo_ok, hi, hit_msip, hit_cmp, hit_time, mapped;
    logic [15:0] base;
    logic [63:0] wd64, rd64;
    logic [7:0]  be64;
    logic [XLEN-1:0] rd_x;

    mtime_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Decode: 32-bit buses see each 64-bit register as two words, PADDR[2] picks the half.
    assign base     = {PADDR[15:3], 3'b000};
    assign lo_ok    = X32 ? (PADDR[1:0] == 2'b00) : (PADDR[2:0] == 3'b000);
    assign hi       = X32 & PADDR[2];
    assign hit_msip = (PADDR == CLINT_MSIP_OFF);
    assign hit_cmp  = lo_ok && (base == CLINT_MTIMECMP_OFF);
    assign hit_time = lo_ok && (base == CLINT_MTIME_OFF);
    assign mapped   = hit_msip | hit_cmp | hit_time;

    generate
        if (XLEN == 32) begin : g_x32
            assign wd64 = {PWDATA, PWDATA};
            assign be64 = hi ? {PSTRB, 4'h0} : {4'h0, PSTRB};
            assign rd_x = hi ? rd64[63:32] : rd64[31:0];
        end else begin : g_x64
            assign wd64 = PWDATA;
            assign be64 = PSTRB;
            assign rd_x = rd64;
        end
    endgenerate

    assign rd64 = hit_msip ? {63'd0, msip_q} :
                  hit_cmp  ? mtimecmp_q :
                  hit_time ? mtime_q : 64'd0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE:   if (PSEL && !PENABLE) state_d = APB_SETUP;
            APB_SETUP:  if (!PSEL) state_d = APB_IDLE;
                        else if (PENABLE) state_d = APB_ACCESS;
            APB_ACCESS: state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    assign access  = (state_q == APB_ACCESS);
    assign commit  = access & PWRITE & mapped;
    assign PREADY  = access;
    assign PSLVERR = access & ~mapped;
    assign PRDATA  = (access & ~PWRITE & mapped) ? rd_x : '0;

    // A committing mtime write suppresses the tick increment for the whole register.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (commit && hit_time) mtime_d = byte_merge(mtime_q, wd64, be64);
        else if (tick)          mtime_d = mtime_q + 64'd1;
        if (commit && hit_cmp)  mtimecmp_d = byte_merge(mtimecmp_q, wd64, be64);
        if (commit && hit_msip && be64[0]) msip_d = wd64[0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= APB_IDLE;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mti_q      <= 1'b0;
            msi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mti_q      <= (mtime_q >= mtimecmp_q);
            msi_q      <= msip_q;
        end
    end

    assign MTIME_CLINT = mtime_q;
    assign MTimerInt   = mti_q;
    assign MSwInt      = msi_q;

endmodule

// File: tb/tb_clint_mtime_timer.sv
// Directed bench for clint_mtime_timer: one XLEN=64 and one XLEN=32 instance on a shared clock/reset.
`timescale 1ns/1ps
module tb_clint_mtime_timer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_psel, a_pen, a_pwr, a_rdy, a_err, a_mti, a_msi;
    logic [15:0] a_addr;
    logic [63:0] a_wd, a_rd, a_mtime;
    logic [7:0]  a_st;

    logic        b_psel, b_pen, b_pwr, b_rdy, b_err, b_mti, b_msi;
    logic [15:0] b_addr;
    logic [31:0] b_wd, b_rd;
    logic [63:0] b_mtime;
    logic [3:0]  b_st;

    int checks = 0;
    int failures = 0;

    clint_mtime_timer #(.XLEN(64), .TICK_DIV(1)) dut64 (
        .clk(clk), .reset(reset), .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwr),
        .PADDR(a_addr), .PWDATA(a_wd), .PSTRB(a_st), .PRDATA(a_rd), .PREADY(a_rdy),
        .PSLVERR(a_err), .MTIME_CLINT(a_mtime), .MTimerInt(a_mti), .MSwInt(a_msi)
    );

    clint_mtime_timer #(.XLEN(32), .TICK_DIV(1)) dut32 (
        .clk(clk), .reset(reset), .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwr),
        .PADDR(b_addr), .PWDATA(b_wd), .PSTRB(b_st), .PRDATA(b_rd), .PREADY(b_rdy),
        .PSLVERR(b_err), .MTIME_CLINT(b_mtime), .MTimerInt(b_mti), .MSwInt(b_msi)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One APB transfer starting at a negedge; returns at the negedge after the commit edge.
    task automatic apb(input bit b32, input bit wr, input logic [15:0] a, input logic [63:0] wd,
                       input logic [7:0] st, output logic [63:0] rd, output logic err);
        logic rdy;
        if (b32) begin
            b_psel = 1'b1; b_pen = 1'b0; b_pwr = wr; b_addr = a; b_wd = wd[31:0]; b_st = st[3:0];
        end else begin
            a_psel = 1'b1; a_pen = 1'b0; a_pwr = wr; a_addr = a; a_wd = wd; a_st = st;
        end
        @(negedge clk);
        rdy = b32 ? b_rdy : a_rdy;
        chk("setup_pready", {63'd0, rdy}, 64'd0);
        if (b32) b_pen = 1'b1; else a_pen = 1'b1;
        @(negedge clk);
        rdy = b32 ? b_rdy : a_rdy;
        chk("access_pready", {63'd0, rdy}, 64'd1);
        rd  = b32 ? {32'd0, b_rd} : a_rd;
        err = b32 ? b_err : a_err;
        @(negedge clk);
        if (b32) begin b_psel = 1'b0; b_pen = 1'b0; end
        else     begin a_psel = 1'b0; a_pen = 1'b0; end
    endtask

    task automatic wr(input bit b32, input logic [15:0] a, input logic [63:0] d, input logic [7:0] st);
        logic [63:0] r;
        logic e;
        apb(b32, 1'b1, a, d, st, r, e);
        chk("wr_pslverr", {63'd0, e}, 64'd0);
    endtask

    task automatic rdchk(input bit b32, input logic [15:0] a, input logic [63:0] exp, input string tag);
        logic [63:0] r;
        logic e;
        apb(b32, 1'b0, a, 64'd0, 8'd0, r, e);
        chk(tag, r, exp);
        chk("rd_pslverr", {63'd0, e}, 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic e;
        a_psel = 0; a_pen = 0; a_pwr = 0; a_addr = 0; a_wd = 0; a_st = 0;
        b_psel = 0; b_pen = 0; b_pwr = 0; b_addr = 0; b_wd = 0; b_st = 0;
        repeat (3) @(negedge clk);

        chk("rst_mtime64", a_mtime, 64'd0);
        chk("rst_mtime32", b_mtime, 64'd0);
        chk("rst_mti", {63'd0, a_mti}, 64'd0);
        chk("rst_msi", {63'd0, a_msi}, 64'd0);
        chk("rst_pready", {63'd0, a_rdy}, 64'd0);
        chk("rst_pslverr", {63'd0, a_err}, 64'd0);
        chk("rst_prdata", a_rd, 64'd0);

        // 1: free run for 10 cycles
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_pready", {63'd0, a_rdy}, 64'd0);
        end
        chk("t1_mtime64", a_mtime, 64'd10);
        chk("t1_mtime32", b_mtime, 64'd10);
        chk("t1_mti", {63'd0, a_mti}, 64'd0);

        // 2: compare crossing and clearing by raising mtimecmp
        wr(0, 16'h4000, 64'h20, 8'hFF);
        wr(0, 16'hBFF8, 64'h1E, 8'hFF);
        chk("t2_mtime_wr", a_mtime, 64'h1E);
        @(negedge clk);
        chk("t2_mtime_1f", a_mtime, 64'h1F);
        chk("t2_mti_1f", {63'd0, a_mti}, 64'd0);
        @(negedge clk);
        chk("t2_mtime_20", a_mtime, 64'h20);
        chk("t2_mti_at20", {63'd0, a_mti}, 64'd0);
        @(negedge clk);
        chk("t2_mti_rise", {63'd0, a_mti}, 64'd1);
        wr(0, 16'h4000, 64'h100, 8'hFF);
        chk("t2_mti_commit", {63'd0, a_mti}, 64'd1);
        @(negedge clk);
        chk("t2_mti_clear", {63'd0, a_mti}, 64'd0);

        // byte strobes and read timing
        wr(0, 16'h4000, 64'hAABB_CCDD_EEFF_1122, 8'h02);
        rdchk(0, 16'h4000, 64'h1100, "cmp_strobe");
        wr(0, 16'hBFF8, 64'h1000, 8'hFF);
        rdchk(0, 16'hBFF8, 64'h1002, "mtime_read");

        // 4: wrap with mtimecmp=0
        wr(0, 16'h4000, 64'h0, 8'hFF);
        wr(0, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("t4_mtime_max", a_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("t4_mtime_wrap", a_mtime, 64'd0);
        chk("t4_mti_wrap", {63'd0, a_mti}, 64'd1);
        @(negedge clk);
        chk("t4_mti_hold", {63'd0, a_mti}, 64'd1);

        // 5: software interrupt
        wr(0, 16'h0000, 64'h1, 8'h01);
        chk("t5_msi_lat", {63'd0, a_msi}, 64'd0);
        @(negedge clk);
        chk("t5_msi_set", {63'd0, a_msi}, 64'd1);
        wr(0, 16'h0000, 64'h0, 8'h00);
        @(negedge clk);
        chk("t5_msi_nostrb", {63'd0, a_msi}, 64'd1);
        wr(0, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rdchk(0, 16'h0000, 64'h1, "t5_msip_raz");

        // 3: XLEN=32 carry across halves and half write on a tick cycle
        wr(1, 16'hBFFC, 64'h0, 8'h0F);
        wr(1, 16'hBFF8, 64'hFFFF_FFFF, 8'h0F);
        chk("t3_mtime_set", b_mtime, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        chk("t3_carry", b_mtime, 64'h0000_0001_0000_0000);
        wr(1, 16'hBFFC, 64'h5, 8'h0F);
        chk("t3_hi_write", b_mtime, 64'h0000_0005_0000_0002);
        rdchk(1, 16'hBFFC, 64'h5, "t3_hi_read");

        // 6: unmapped offsets
        apb(0, 1'b0, 16'h1234, 64'd0, 8'd0, r, e);
        chk("t6_err_1234", {63'd0, e}, 64'd1);
        chk("t6_rd_1234", r, 64'd0);
        apb(0, 1'b0, 16'hBFFC, 64'd0, 8'd0, r, e);
        chk("t6_err_bffc64", {63'd0, e}, 64'd1);
        chk("t6_rd_bffc64", r, 64'd0);
        apb(0, 1'b1, 16'h4008, 64'h55, 8'hFF, r, e);
        chk("t6_err_wr", {63'd0, e}, 64'd1);
        rdchk(0, 16'h4000, 64'h0, "t6_unmapped_wi");

        // 6: reset during SETUP aborts the transfer
        a_psel = 1'b1; a_pen = 1'b0; a_pwr = 1'b0; a_addr = 16'hBFF8;
        @(negedge clk);
        reset = 1'b0;
        a_pen = 1'b1;
        @(negedge clk);
        chk("t6_rst_pready", {63'd0, a_rdy}, 64'd0);
        chk("t6_rst_prdata", a_rd, 64'd0);
        chk("t6_rst_mtime", a_mtime, 64'd0);
        chk("t6_rst_msi", {63'd0, a_msi}, 64'd0);
        chk("t6_rst_mti", {63'd0, a_mti}, 64'd0);
        a_psel = 1'b0; a_pen = 1'b0;
        @(negedge clk);
        chk("t6_rst_pready2", {63'd0, a_rdy}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_post_mtime", a_mtime, 64'd1);
        rdchk(0, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, "t6_post_cmp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
